i2s_tx: RTL and testbench

//  I2S master transmitter: serializes stereo PCM frames onto i2s_sd toward an external DAC/codec.

---
 rtl/i2s_pkg.sv | 29 ++
 rtl/i2s_clk_gen.sv | 81 ++++++++
 rtl/i2s_tx.sv | 161 ++++++++++++++++
 tb/tb_i2s_tx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// -----------------------------------------------------------------------------
// i2s_pkg
// Shared I2S definitions used by both the transmit and capture paths.
//   SLOT_WIDTH / FRAME_BITS : fixed 32-bit slots, 64 SCK per stereo frame
//   BIT_CNT_*               : frame bit counter width, reset and wrap values
//   i2s_frame_t             : one 24-bit stereo sample pair
//   ws_for_bit()            : word-select level for a given frame bit position
// -----------------------------------------------------------------------------
package i2s_pkg;

  localparam int SLOT_WIDTH = 32;
  localparam int FRAME_BITS = 64;
  localparam int BIT_CNT_W  = 6;

  // Reset parks the counter two strobes before the first frame load.
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_RST  = 6'd62;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = 6'd63;

  typedef struct packed {
    logic [23:0] left;
    logic [23:0] right;
  } i2s_frame_t;

  // WS leads the slot MSB by one SCK: low for {63, 0..30}, high for {31..62}.
  function automatic logic ws_for_bit(input logic [BIT_CNT_W-1:0] bit_pos);
    return (bit_pos >= 6'd31) && (bit_pos <= 6'd62);
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// -----------------------------------------------------------------------------
// i2s_clk_gen
// I2S master timing: divides clk down to SCK, tracks the frame bit position
// and drives WS. Reusable by the capture path.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   en        in   1 = run; 0 = park SCK low and hold counters at reset values
//   sck       out  serial bit clock, 50% duty, period 2*CLK_DIV clk
//   ws        out  word select (0 = left, 1 = right), changes on SCK fall
//   fall_stb  out  high in the clk cycle whose closing edge takes SCK 1->0
//   bit_cnt   out  current frame bit position 0..63
// -----------------------------------------------------------------------------
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic                 sck,
  output logic                 ws,
  output logic                 fall_stb,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 sck_q, sck_d;
  logic                 ws_q, ws_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 div_tc;

  always_comb begin
    div_tc    = en && (div_cnt_q == DIV_LAST);
    fall_stb  = div_tc && sck_q;
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    ws_d      = ws_q;
    bit_cnt_d = bit_cnt_q;
    if (!en) begin
      // Synchronous park: everything back to the post-reset position.
      div_cnt_d = '0;
      sck_d     = 1'b0;
      ws_d      = 1'b1;
      bit_cnt_d = BIT_CNT_RST;
    end else begin
      div_cnt_d = div_tc ? '0 : div_cnt_q + 1'b1;
      if (div_tc) begin
        sck_d = ~sck_q;
      end
      if (fall_stb) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        ws_d      = ws_for_bit(bit_cnt_d);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
      ws_q      <= 1'b1;
      bit_cnt_q <= BIT_CNT_RST;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
      ws_q      <= ws_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign sck     = sck_q;
  assign ws      = ws_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/i2s_tx.sv
// -----------------------------------------------------------------------------
// i2s_tx
// Philips I2S master transmitter. Accepts one stereo frame per valid/ready
// handshake into a one-frame holding buffer and serialises it MSB first, one
// SCK after the WS edge, toward an external DAC/codec.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   en           in   1 = run; 0 = halt, SCK parked low, frame in flight dropped
//   s_left       in   left sample, two's complement, DATA_WIDTH bits
//   s_right      in   right sample, DATA_WIDTH bits
//   s_valid      in   frame offered
//   s_ready      out  holding buffer empty (registered)
//   i2s_sck      out  serial bit clock
//   i2s_ws       out  word select, 0 = left, 1 = right
//   i2s_sd       out  serial data, changes on SCK fall
//   frame_start  out  1-clk pulse when a frame is loaded into the shifter
//   underrun     out  1-clk pulse when a frame starts with the buffer empty
//
// Build option
//   I2S_TX_HOLD_LAST_EN : when defined, an underrun repeats the last
//                         transmitted frame (zero after reset) instead of
//                         sending silence.
// -----------------------------------------------------------------------------
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] s_left,
  input  logic [DATA_WIDTH-1:0] s_right,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  i2s_sck,
  output logic                  i2s_ws,
  output logic                  i2s_sd,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int PAD = SLOT_WIDTH - DATA_WIDTH;

  logic                 fall_stb;
  logic [BIT_CNT_W-1:0] bit_cnt;

  i2s_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sck      (i2s_sck),
    .ws       (i2s_ws),
    .fall_stb (fall_stb),
    .bit_cnt  (bit_cnt)
  );

  // Frames are stored already laid out as two left-justified 32-bit slots,
  // so the shifter simply walks MSB to LSB across the whole 64-bit frame.
  logic [FRAME_BITS-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  sd_q, sd_d;
  logic                  frame_start_q, frame_start_d;
  logic                  underrun_q, underrun_d;
  logic [SLOT_WIDTH-1:0] in_left_slot, in_right_slot;
  logic                  accept;
  logic                  load;
`ifdef I2S_TX_HOLD_LAST_EN
  logic [FRAME_BITS-1:0] last_q, last_d;
`endif

  always_comb begin
    in_left_slot  = SLOT_WIDTH'(s_left) << PAD;
    in_right_slot = SLOT_WIDTH'(s_right) << PAD;
    accept        = s_valid && !hold_full_q;
    load          = fall_stb && (bit_cnt == BIT_CNT_LAST);

    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    shift_d       = shift_q;
    sd_d          = sd_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
    last_d        = last_q;
`endif

    // Accept and load are mutually exclusive: load needs a full buffer,
    // accept needs an empty one. Accepting stays possible while en=0.
    if (accept) begin
      hold_d      = {in_left_slot, in_right_slot};
      hold_full_d = 1'b1;
    end

    if (!en) begin
      shift_d = '0;
      sd_d    = 1'b0;
    end else if (load) begin
      frame_start_d = 1'b1;
      if (hold_full_q) begin
        shift_d     = hold_q;
        hold_full_d = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
        last_d      = hold_q;
`endif
      end else begin
        underrun_d = 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
        shift_d    = last_q;
`else
        shift_d    = '0;
`endif
      end
      // Left MSB goes out in the same update as the load.
      sd_d = shift_d[FRAME_BITS-1];
    end else if (fall_stb) begin
      shift_d = shift_q << 1;
      sd_d    = shift_d[FRAME_BITS-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      shift_q       <= '0;
      sd_q          <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      shift_q       <= shift_d;
      sd_q          <= sd_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

`ifdef I2S_TX_HOLD_LAST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign s_ready     = ~hold_full_q;
  assign i2s_sd      = sd_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx
// Directed bench for i2s_tx with a behavioural I2S receiver that samples SD on
// SCK rise and frames words on WS transitions.
// -----------------------------------------------------------------------------
module tb_i2s_tx;

  localparam int CLK_DIV = 2;
  localparam int DW      = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [DW-1:0] s_left = '0;
  logic [DW-1:0] s_right = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          i2s_sck, i2s_ws, i2s_sd;
  logic          frame_start, underrun;

  always #5 clk = ~clk;

  i2s_tx #(
    .CLK_DIV    (CLK_DIV),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .s_left      (s_left),
    .s_right     (s_right),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .i2s_sck     (i2s_sck),
    .i2s_ws      (i2s_ws),
    .i2s_sd      (i2s_sd),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- receiver model ----------------
  logic        sck_p = 1'b0;
  logic        ws_p = 1'b1;
  logic [31:0] acc = '0;
  logic [31:0] left_w = '0;
  logic        left_ok = 1'b0;
  int          bit_n = 0;
  int          und_n = 0;
  int          fs_n = 0;
  int          clk_cnt = 0;
  int          last_rise = 0;
  int          sck_per = 0;
  int          len_lo = 0;
  int          len_hi = 0;
  int          fall_cnt = 0;
  logic        sd_one = 1'b0;
  logic [23:0] q_l[$];
  logic [23:0] q_r[$];
  logic [15:0] q_pad[$];
  int          q_und[$];
  int          q_fs[$];

  always @(negedge clk) begin
    clk_cnt++;
    if (!rst_n || !en) begin
      sck_p   = 1'b0;
      ws_p    = 1'b1;
      bit_n   = 0;
      left_ok = 1'b0;
      und_n   = 0;
      fs_n    = 0;
    end else begin
      if (underrun)    und_n++;
      if (frame_start) fs_n++;
      if (i2s_sd)      sd_one = 1'b1;
      if (sck_p && !i2s_sck) fall_cnt++;
      if (!sck_p && i2s_sck) begin
        sck_per   = clk_cnt - last_rise;
        last_rise = clk_cnt;
        acc       = {acc[30:0], i2s_sd};
        bit_n++;
        if (i2s_ws != ws_p) begin
          if (!ws_p) begin
            len_lo  = bit_n;
            left_w  = acc;
            left_ok = (bit_n == 32);
          end else begin
            len_hi = bit_n;
            if (left_ok && bit_n == 32) begin
              q_l.push_back(left_w[31:8]);
              q_r.push_back(acc[31:8]);
              q_pad.push_back({left_w[7:0], acc[7:0]});
              q_und.push_back(und_n);
              q_fs.push_back(fs_n);
            end
            left_ok = 1'b0;
            und_n   = 0;
            fs_n    = 0;
          end
          bit_n = 0;
        end
        ws_p = i2s_ws;
      end
      sck_p = i2s_sck;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_q();
    q_l.delete(); q_r.delete(); q_pad.delete(); q_und.delete(); q_fs.delete();
  endtask

  task automatic wait_fs(input string tag);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!frame_start && t < 3000);
    check(tag, frame_start, 1'b1);
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r, input string tag);
    int t = 0;
    while (!s_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_rdy"}, s_ready, 1'b1);
    s_left  = l;
    s_right = r;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check({tag, "_busy"}, s_ready, 1'b0);
  endtask

  // s_ready must come back exactly on the frame-load edge.
  task automatic wait_load(input string tag);
    int t = 0;
    while (!s_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_ld"}, frame_start, 1'b1);
  endtask

  task automatic wait_q(input int n, input string tag);
    int t = 0;
    while (q_l.size() < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check(tag, (q_l.size() >= n), 1'b1);
  endtask

  task automatic wait_bit(input logic [5:0] b, input string tag);
    int t = 0;
    while (dut.bit_cnt != b && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check(tag, dut.bit_cnt, b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [23:0] el, er;
    logic [47:0] exp_f;
    int          und_sum;
    int          f0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_sck", i2s_sck, 1'b0);
    check("rst_ws", i2s_ws, 1'b1);
    check("rst_sd", i2s_sd, 1'b0);
    check("rst_ready", s_ready, 1'b1);
    check("rst_fs", frame_start, 1'b0);
    check("rst_und", underrun, 1'b0);
    check("rst_bitcnt", dut.bit_cnt, 6'd62);

    // 1: idle run, all underruns
    rst_n = 1'b1;
    en    = 1'b1;
    clear_q();
    wait_q(3, "t1_frames");
    check("t1_sck_period", sck_per, 2 * CLK_DIV);
    check("t1_ws_low_len", len_lo, 32);
    check("t1_ws_high_len", len_hi, 32);
    check("t1_sd_zero", sd_one, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t1_und_per_frame", q_und[i], 1);
      check("t1_fs_per_frame", q_fs[i], 1);
      check("t1_data", {q_l[i], q_r[i]}, 48'h0);
    end

    // 2: single frame
    wait_fs("t2_sync");
    clear_q();
    send(24'h123456, 24'h7FFFFF, "t2");
    wait_load("t2");
    wait_q(2, "t2_frames");
    check("t2_prev_und", q_und[0], 1);
    check("t2_left", q_l[1], 24'h123456);
    check("t2_right", q_r[1], 24'h7FFFFF);
    check("t2_pad", q_pad[1], 16'h0);
    check("t2_und", q_und[1], 0);
    check("t2_fs", q_fs[1], 1);

    // 3: back-to-back stream
    wait_fs("t3_sync");
    clear_q();
    for (int i = 0; i < 40; i++) begin
      el = 24'h100000 + 24'(i);
      er = 24'h200000 + 24'(i);
      send(el, er, "t3");
      wait_load("t3");
    end
    wait_q(41, "t3_frames");
    und_sum = 0;
    for (int i = 0; i < 40; i++) begin
      exp_f = {24'h100000 + 24'(i), 24'h200000 + 24'(i)};
      check("t3_frame", {q_l[i+1], q_r[i+1]}, exp_f);
      und_sum += q_und[i+1];
    end
    check("t3_no_underrun", und_sum, 0);

    // 4: gap between frames 0 and 2
    wait_fs("t4_sync");
    clear_q();
    send(24'h0A0A0A, 24'h0B0B0B, "t4a");
    wait_load("t4a");
    wait_fs("t4_gap");
    send(24'h0C0C0C, 24'h0D0D0D, "t4c");
    wait_load("t4c");
    wait_q(4, "t4_frames");
    check("t4_f0", {q_l[1], q_r[1]}, 48'h0A0A0A_0B0B0B);
`ifdef I2S_TX_HOLD_LAST_EN
    exp_f = 48'h0A0A0A_0B0B0B;
`else
    exp_f = 48'h0;
`endif
    check("t4_gap_data", {q_l[2], q_r[2]}, exp_f);
    check("t4_gap_und", q_und[2], 1);
    check("t4_f2", {q_l[3], q_r[3]}, 48'h0C0C0C_0D0D0D);
    check("t4_und_total", q_und[1] + q_und[2] + q_und[3], 1);

    // 5: en drop mid-frame, held frame survives
    wait_fs("t5_sync");
    send(24'h111111, 24'h222222, "t5d");
    wait_load("t5d");
    send(24'h333333, 24'h444444, "t5e");
    wait_bit(6'd40, "t5_bit40");
    en = 1'b0;
    @(negedge clk);
    check("t5_sck", i2s_sck, 1'b0);
    check("t5_ws", i2s_ws, 1'b1);
    check("t5_sd", i2s_sd, 1'b0);
    check("t5_bitcnt", dut.bit_cnt, 6'd62);
    check("t5_held", s_ready, 1'b0);
    repeat (10) @(negedge clk);
    clear_q();
    f0 = fall_cnt;
    en = 1'b1;
    wait_fs("t5_reload");
    check("t5_reload_und", underrun, 1'b0);
    @(negedge clk);
    check("t5_falls", fall_cnt - f0, 2);
    wait_q(1, "t5_frames");
    check("t5_frame", {q_l[0], q_r[0]}, 48'h333333_444444);

    // 6: async reset mid right slot
    send(24'h555555, 24'h666666, "t6f");
    wait_load("t6f");
    send(24'h777777, 24'h888888, "t6g");
    wait_bit(6'd45, "t6_bit45");
    rst_n = 1'b0;
    #1;
    check("t6_sck", i2s_sck, 1'b0);
    check("t6_ws", i2s_ws, 1'b1);
    check("t6_sd", i2s_sd, 1'b0);
    check("t6_ready", s_ready, 1'b1);
    check("t6_fs", frame_start, 1'b0);
    check("t6_und", underrun, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    wait_fs("t6_first");
    check("t6_first_und", underrun, 1'b1);
    wait_q(1, "t6_frames");
    check("t6_frame", {q_l[0], q_r[0]}, 48'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
